// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command receiver: FSM states, SPI mode
// and the frame-length helper used to size the shift register and bit counter.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } spi_state_e;

  localparam bit SPI_CPOL = 1'b0;
  localparam bit SPI_CPHA = 1'b0;

  // A parity frame carries one trailing odd-parity bit after the data bits.
  function automatic int frame_len(input int cmd_w, input bit parity_en);
    return parity_en ? cmd_w + 1 : cmd_w;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for the asynchronous SPI pads, with a sample-edge
// detector on dclk taken from the same stage that mosi is presented from.
module spi_pin_sync
  import spi_cmd_pkg::*;
#(
  parameter int SYNC_STG = 2
) (
  input  logic clk50m,
  input  logic rst_n,
  input  logic dclk_i,
  input  logic mosi_i,
  input  logic cs_n_i,
  output logic dclk_rise_o,
  output logic mosi_o,
  output logic cs_n_o
);

  logic [SYNC_STG-1:0] dclk_q;
  logic [SYNC_STG-1:0] mosi_q;
  logic [SYNC_STG-1:0] cs_n_q;
  logic                dclk_last_q;

  // cs_n resets to its inactive level so reset never looks like a frame start.
  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      dclk_q      <= {SYNC_STG{SPI_CPOL}};
      mosi_q      <= '0;
      cs_n_q      <= '1;
      dclk_last_q <= SPI_CPOL;
    end else begin
      dclk_q      <= {dclk_q[SYNC_STG-2:0], dclk_i};
      mosi_q      <= {mosi_q[SYNC_STG-2:0], mosi_i};
      cs_n_q      <= {cs_n_q[SYNC_STG-2:0], cs_n_i};
      dclk_last_q <= dclk_q[SYNC_STG-1];
    end
  end

  assign dclk_rise_o = (SPI_CPOL ^ SPI_CPHA) ? (~dclk_q[SYNC_STG-1] & dclk_last_q)
                                             : (dclk_q[SYNC_STG-1] & ~dclk_last_q);
  assign mosi_o      = mosi_q[SYNC_STG-1];
  assign cs_n_o      = cs_n_q[SYNC_STG-1];

endmodule

// File: rtl/spi_cmd_rx.sv
// SPI slave command receiver: deserialises MSB-first frames into a valid/ready
// holding register. Define CMD_PARITY_EN to append and check an odd-parity bit.
module spi_cmd_rx
  import spi_cmd_pkg::*;
#(
  parameter int CMD_W    = 16,
  parameter int SYNC_STG = 2
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic             dclk,
  input  logic             mosi,
  input  logic             cs_n,
  output logic [CMD_W-1:0] cmd_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             frame_err,
  output logic             overrun
);

`ifdef CMD_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int FRAME_LEN = frame_len(CMD_W, PARITY_EN);
  localparam int CNT_W     = $clog2(CMD_W + 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  logic dclk_rise, mosi_s, cs_n_s;

  spi_pin_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk50m      (clk50m),
    .rst_n       (rst_n),
    .dclk_i      (dclk),
    .mosi_i      (mosi),
    .cs_n_i      (cs_n),
    .dclk_rise_o (dclk_rise),
    .mosi_o      (mosi_s),
    .cs_n_o      (cs_n_s)
  );

  spi_state_e           state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic                 done_q, done_d;
  logic [CMD_W-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic [CMD_W-1:0]     word;
  logic                 word_ok;

`ifdef CMD_PARITY_EN
  assign word    = shift_q[FRAME_LEN-1:1];
  assign word_ok = ^shift_q;
`else
  assign word    = shift_q;
  assign word_ok = 1'b1;
`endif

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    // A last-bit edge wins over a coincident cs_n rise: that frame is complete.
    case (state_q)
      IDLE: begin
        if (!cs_n_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        if (dclk_rise && bit_cnt_q == LAST_CNT) begin
          shift_d   = {shift_q[FRAME_LEN-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          done_d    = 1'b1;
          state_d   = DONE;
        end else if (cs_n_s) begin
          ferr_d  = (bit_cnt_q != '0) || dclk_rise;
          state_d = IDLE;
        end else if (dclk_rise) begin
          shift_d   = {shift_q[FRAME_LEN-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (cs_n_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && cmd_ready) valid_d = 1'b0;

    // Commit one cycle after the frame's last bit; a full, unaccepted holder drops it.
    if (done_q) begin
      if (!word_ok) begin
        ferr_d = 1'b1;
      end else if (!valid_q || cmd_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign cmd_data  = data_q;
  assign cmd_valid = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// Directed bench for spi_cmd_rx: an expected-word queue and pulse counters are
// checked every clock, plus hand-computed literal checks per scenario.
module tb_spi_cmd_rx;

`ifdef CMD_PARITY_EN
  localparam int FLEN = 17;
`else
  localparam int FLEN = 16;
`endif

  logic        clk50m;
  logic        rst_n;
  logic        dclk;
  logic        mosi;
  logic        cs_n;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        frame_err;
  logic        overrun;

  int          errors = 0;
  int          checks = 0;
  int          ferr_total = 0;
  int          ovr_total = 0;
  int          ferr_base = 0;
  int          ovr_base = 0;
  logic [15:0] exp_q[$];

  spi_cmd_rx #(.CMD_W(16), .SYNC_STG(2)) dut (
    .clk50m    (clk50m),
    .rst_n     (rst_n),
    .dclk      (dclk),
    .mosi      (mosi),
    .cs_n      (cs_n),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk50m = 1'b0;
  always #10 clk50m = ~clk50m;

  // Per-cycle compare: any presented word must be the oldest one still owed.
  initial begin
    forever begin
      @(negedge clk50m);
      if (rst_n) begin
        if (cmd_valid === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_valid: cmd_data=%h valid=1, required valid=0", cmd_data);
          end else begin
            if (cmd_data !== exp_q[0]) begin
              errors++;
              $display("FAIL cmd_data: got %h expected %h", cmd_data, exp_q[0]);
            end
            if (cmd_ready === 1'b1) begin
              $display("xfer data=%h", exp_q[0]);
              void'(exp_q.pop_front());
            end
          end
        end
        if (frame_err === 1'b1) ferr_total++;
        if (overrun === 1'b1) ovr_total++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk50m);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [15:0] w);
`ifdef CMD_PARITY_EN
    return {15'd0, w, ~^w};
`else
    return {16'd0, w};
`endif
  endfunction

  task automatic send_bits(input logic [31:0] bits, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      tick(half);
      dclk = 1'b1;
      tick(half);
      dclk = 1'b0;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int half);
    cs_n = 1'b0;
    tick(half);
    send_bits(frame_of(w), FLEN, half);
    tick(half);
    cs_n = 1'b1;
    tick(2 * half);
  endtask

  task automatic check_end(input string name, input int e_ferr, input int e_ovr);
    tick(10);
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_frame_err"}, ferr_total - ferr_base, e_ferr);
    chk({name, "_overrun"}, ovr_total - ovr_base, e_ovr);
    ferr_base = ferr_total;
    ovr_base  = ovr_total;
  endtask

  logic [31:0] f;
  logic [15:0] d_seen;
  int          lat;

  initial begin
    rst_n = 1'b0; dclk = 1'b0; mosi = 1'b0; cs_n = 1'b1; cmd_ready = 1'b0;
    tick(3);
    @(negedge clk50m);
    chk("rst_data", cmd_data, 0);
    chk("rst_valid", cmd_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    @(posedge clk50m); #2;
    rst_n = 1'b1;
    tick(4);

    // 1: single frame, ready high, with last-edge latency measurement
    cmd_ready = 1'b1;
    exp_q.push_back(16'hA55A);
    f = frame_of(16'hA55A);
    cs_n = 1'b0;
    tick(4);
    send_bits(f >> 1, FLEN - 1, 4);
    mosi = f[0];
    tick(4);
    dclk = 1'b1;
    lat = -1;
    d_seen = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk50m);
      if (cmd_valid && lat < 0) begin
        lat = k;
        d_seen = cmd_data;
      end
    end
    @(posedge clk50m); #2;
    dclk = 1'b0;
    tick(4);
    cs_n = 1'b1;
    tick(8);
    chk("t1_latency", lat, 4);
    chk("t1_data", d_seen, 16'hA55A);
    check_end("t1", 0, 0);

    // 2: holder full, second frame overruns and is dropped
    cmd_ready = 1'b0;
    exp_q.push_back(16'h1234);
    send_word(16'h1234, 4);
    send_word(16'hBEEF, 4);
    tick(6);
    @(negedge clk50m);
    chk("t2_held_data", cmd_data, 16'h1234);
    chk("t2_held_valid", cmd_valid, 1);
    @(posedge clk50m); #2;
    cmd_ready = 1'b1;
    check_end("t2", 0, 1);

    // 3: short frame of 9 bits, then a good frame
    cs_n = 1'b0;
    tick(4);
    send_bits(32'h1A5, 9, 4);
    tick(4);
    cs_n = 1'b1;
    tick(8);
    exp_q.push_back(16'h00FF);
    send_word(16'h00FF, 4);
    check_end("t3", 1, 0);

    // 4: four extra dclk edges after a full frame
    exp_q.push_back(16'hC3C3);
    f = (frame_of(16'hC3C3) << 4) | 32'hB;
    cs_n = 1'b0;
    tick(4);
    send_bits(f, FLEN + 4, 4);
    tick(4);
    cs_n = 1'b1;
    tick(8);
    check_end("t4", 0, 0);

    // 5: reset after 7 bits discards the partial word
    cs_n = 1'b0;
    tick(4);
    send_bits(32'h55, 7, 4);
    rst_n = 1'b0;
    cs_n = 1'b1;
    @(negedge clk50m);
    chk("t5_rst_data", cmd_data, 0);
    chk("t5_rst_valid", cmd_valid, 0);
    chk("t5_rst_frame_err", frame_err, 0);
    chk("t5_rst_overrun", overrun, 0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    exp_q.push_back(16'h8001);
    send_word(16'h8001, 4);
    check_end("t5", 0, 0);

    // 6: fastest dclk, back-to-back frames
    exp_q.push_back(16'h5A5A);
    exp_q.push_back(16'h0F0F);
    exp_q.push_back(16'hFFFE);
    send_word(16'h5A5A, 2);
    send_word(16'h0F0F, 2);
    send_word(16'hFFFE, 2);
    check_end("t6_fast", 0, 0);

`ifdef CMD_PARITY_EN
    // 6p: good parity accepted, bad parity rejected with frame_err
    exp_q.push_back(16'h0001);
    cs_n = 1'b0;
    tick(4);
    send_bits({15'd0, 16'h0001, 1'b0}, 17, 4);
    tick(4);
    cs_n = 1'b1;
    tick(8);
    cs_n = 1'b0;
    tick(4);
    send_bits({15'd0, 16'h0001, 1'b1}, 17, 4);
    tick(4);
    cs_n = 1'b1;
    tick(8);
    check_end("t6_parity", 1, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
